mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: grant-state encoding and the
// default starvation limit used when MEM_ARB_STARVE_GUARD_EN is defined.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_DMA  = 2'd2
  } gnt_e;

  localparam int STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the core (fixed priority) and a DMA/video requester.
// Optional starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
`ifdef MEM_ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_o_data,
  output logic [DATA_W-1:0] cpu_i_data,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_o_data,
  input  logic [DATA_W-1:0] mem_i_data,
  output logic [1:0]        last_gnt_dbg
);

  // Handshakes: a CPU access issues in any cycle with cpu_req=1 and cpu_ready=1,
  // its read data appears on cpu_i_data the following cycle. DMA holds dma_req
  // and its fields stable until dma_gnt=1; dma_ack pulses the cycle after dma_gnt
  // with dma_rdata valid.

  gnt_e              last_gnt;
  gnt_e              next_gnt;
  logic              cpu_gnt;
  logic              force_dma;
  logic [DATA_W-1:0] cpu_data_q;
  logic [DATA_W-1:0] dma_data_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt;

  assign force_dma = dma_req && (starve_cnt >= 4'(STARVE_LIMIT));

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (!dma_req || dma_gnt) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != 4'hF) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  assign force_dma = 1'b0;
`endif

  always_comb begin
    cpu_gnt     = 1'b0;
    dma_gnt     = 1'b0;
    next_gnt    = S_IDLE;
    mem_we      = 1'b0;
    if (!reset) begin
      if (force_dma)    dma_gnt = 1'b1;
      else if (cpu_req) cpu_gnt = 1'b1;
      else if (dma_req) dma_gnt = 1'b1;
    end
    if (cpu_gnt)      next_gnt = S_CPU;
    else if (dma_gnt) next_gnt = S_DMA;

    if (cpu_gnt)      mem_we = cpu_we;
    else if (dma_gnt) mem_we = dma_we;
    mem_address = dma_gnt ? dma_address : cpu_address;
    mem_o_data  = dma_gnt ? dma_wdata   : cpu_o_data;
    cpu_ready   = reset || !cpu_req || cpu_gnt;

    // Return path is qualified by reset so an issue cut off by reset never completes.
    dma_ack    = !reset && (last_gnt == S_DMA);
    cpu_i_data = reset ? '0 : ((last_gnt == S_CPU) ? mem_i_data : cpu_data_q);
    dma_rdata  = reset ? '0 : ((last_gnt == S_DMA) ? mem_i_data : dma_data_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt   <= S_IDLE;
      cpu_data_q <= '0;
      dma_data_q <= '0;
    end else begin
      last_gnt <= next_gnt;
      if (last_gnt == S_CPU) cpu_data_q <= mem_i_data;
      if (last_gnt == S_DMA) dma_data_q <= mem_i_data;
    end
  end

  assign last_gnt_dbg = last_gnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level reference model and reference memory.
module tb_mem_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int LIMIT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_o_data, cpu_i_data;
  logic        cpu_ready;
  logic        dma_req, dma_we;
  logic [15:0] dma_address;
  logic [7:0]  dma_wdata, dma_rdata;
  logic        dma_gnt, dma_ack;
  logic [15:0] mem_address;
  logic        mem_we;
  logic [7:0]  mem_o_data, mem_i_data;
  logic [1:0]  last_gnt_dbg;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address),
    .cpu_o_data(cpu_o_data), .cpu_i_data(cpu_i_data), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_address(dma_address),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_ack(dma_ack),
    .dma_rdata(dma_rdata), .mem_address(mem_address), .mem_we(mem_we),
    .mem_o_data(mem_o_data), .mem_i_data(mem_i_data),
    .last_gnt_dbg(last_gnt_dbg)
  );

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Environment RAM, driven only by the DUT's memory port (plus a preload port).
  logic [7:0]  ram     [0:65535];
  bit          written [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always @(posedge clock) begin
    if (pl_en) begin
      ram[pl_addr]     <= pl_data;
      written[pl_addr] <= 1'b1;
    end else if (mem_we) begin
      ram[mem_address]     <= mem_o_data;
      written[mem_address] <= 1'b1;
    end
    mem_i_data <= written[mem_address] ? ram[mem_address] : init_byte(mem_address);
  end

  // Reference model: who owns this cycle, what each requester sees next cycle.
  logic [7:0] ref_mem [int];
  int         m_starve   = 0;
  bit         m_ack      = 1'b0;
  logic [7:0] m_cpu_data = '0;
  logic [7:0] m_dma_data = '0;
  int         g          = 0;   // 0 none, 1 cpu, 2 dma

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    #1;
    if (reset)                                     g = 0;
    else if (GUARD && dma_req && m_starve >= LIMIT) g = 2;
    else if (cpu_req)                              g = 1;
    else if (dma_req)                              g = 2;
    else                                           g = 0;

    chk("cpu_ready", cpu_ready, (cpu_req && !reset && g != 1) ? 1'b0 : 1'b1);
    chk("dma_gnt", dma_gnt, g == 2);
    chk("mem_we", mem_we, (g == 1) ? cpu_we : (g == 2) ? dma_we : 1'b0);
    chk("mem_address", mem_address, (g == 2) ? dma_address : cpu_address);
    if (g == 1 && cpu_we) chk("mem_o_data_cpu", mem_o_data, cpu_o_data);
    if (g == 2 && dma_we) chk("mem_o_data_dma", mem_o_data, dma_wdata);
    chk("dma_ack", dma_ack, m_ack && !reset);
    chk("cpu_i_data", cpu_i_data, reset ? 8'h00 : m_cpu_data);
    if (reset || m_ack) chk("dma_rdata", dma_rdata, reset ? 8'h00 : m_dma_data);

    @(posedge clock);
    if (reset) begin
      m_starve = 0; m_ack = 1'b0; m_cpu_data = '0; m_dma_data = '0;
    end else begin
      m_ack = (g == 2);
      if (g == 1) begin
        m_cpu_data = ref_rd(cpu_address);
        if (cpu_we) ref_mem[int'(cpu_address)] = cpu_o_data;
      end else if (g == 2) begin
        m_dma_data = ref_rd(dma_address);
        if (dma_we) ref_mem[int'(dma_address)] = dma_wdata;
      end
      if (dma_req && g != 2) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
      else                   m_starve = 0;
    end
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_address = '0; cpu_o_data = '0;
    dma_req = 0; dma_we = 0; dma_address = '0; dma_wdata = '0;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    idle_inputs();
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[int'(a)] = d;
    cycle();
    pl_en = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);

    // Reset with both requesters active.
    cpu_req = 1; dma_req = 1; dma_address = 16'h0040;
    repeat (3) cycle();
    reset = 1'b0;
    idle_inputs();
    cycle();

    // CPU read alone.
    preload(16'h0100, 8'hA5);
    cpu_req = 1; cpu_address = 16'h0100;
    cycle();
    cpu_req = 0;
    repeat (2) cycle();

    // DMA write alone, then CPU read back of the written byte.
    dma_req = 1; dma_we = 1; dma_address = 16'h2000; dma_wdata = 8'h3C;
    cycle();
    idle_inputs();
    cycle();
    cpu_req = 1; cpu_address = 16'h2000;
    cycle();
    cpu_req = 0;
    cycle();

    // Sustained contention.
    cpu_req = 1; cpu_we = 1; cpu_o_data = 8'h11;
    dma_req = 1; dma_we = 0; dma_address = 16'h0300;
    for (int i = 0; i < 27; i++) begin
      cpu_address = 16'h0400 + 16'(i);
      cycle();
    end
    idle_inputs();
    cycle();

    // Reset in the cycle after a DMA read issue.
    dma_req = 1; dma_address = 16'h0010;
    cycle();
    idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (2) cycle();

    // Back-to-back DMA reads.
    preload(16'h0010, 8'hC1);
    preload(16'h0011, 8'hC2);
    preload(16'h0012, 8'hC3);
    for (int i = 0; i < 3; i++) begin
      dma_req = 1; dma_we = 0; dma_address = 16'h0010 + 16'(i);
      cycle();
    end
    idle_inputs();
    repeat (2) cycle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 63) == 0);
      cpu_req     = $urandom_range(0, 1);
      cpu_we      = $urandom_range(0, 1);
      cpu_address = 16'($urandom_range(0, 31));
      cpu_o_data  = 8'($urandom);
      if (!dma_req || g == 2) begin
        dma_req     = $urandom_range(0, 1);
        dma_we      = $urandom_range(0, 1);
        dma_address = 16'($urandom_range(0, 31));
        dma_wdata   = 8'($urandom);
      end
      cycle();
    end
    reset = 1'b0;
    idle_inputs();
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
